reg_file_sb: RTL and testbench

- Parametrised integer register file with a per-register busy scoreboard. It is the next generation of the core's 32x64 register file.
- Provides 2 combinational read ports and 1 synchronous write port.
- Register 0 is hardwired to zero.
- A post-reset clear sequencer zeroes the array one entry per cycle before the block reports ready.
- Sits between decode (read and issue) and writeback (write and busy clear) in the pipeline.

---
 rtl/reg_file_sb.sv | 160 ++++++++++++++++
 tb/tb_reg_file_sb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with per-register busy scoreboard.
// Optional same-cycle write forwarding: define REG_FILE_FORWARD_EN.
module reg_file_sb #(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            ready
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   clr_ptr;
  logic [NREGS-1:0] busy_q;
  logic [XLEN-1:0] mem [NREGS];

  logic            run;
  logic            wr_ok;
  logic            iss_ok;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT once the last entry has been cleared.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: if (clr_ptr == LAST) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Outputs and qualified strobes; ready comes straight from the state flop.
  always_comb begin
    run    = (state_q == RUN);
    ready  = run;
    wr_ok  = run && wr_en && (wr_addr != '0);
    iss_ok = run && issue_en && (issue_rd != '0);
  end

  // Clear pointer walks the array during INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ptr <= '0;
    end else if (state_q == INIT) begin
      clr_ptr <= clr_ptr + AW'(1);
    end
  end

  // Single array write port shared by the clear sequencer and writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (1'b1)
      !run: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
      end
      wr_ok: mem_we = 1'b1;
      default: mem_we = 1'b0;
    endcase
  end

  // Array storage; not reset, cleared by the sequencer instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Busy bits: writeback clears, issue sets, set wins on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      if (wr_ok)  busy_q[wr_addr]  <= 1'b0;
      if (iss_ok) busy_q[issue_rd] <= 1'b1;
    end
  end

`ifdef REG_FILE_FORWARD_EN
  logic fwd1;
  logic fwd2;
  logic fwd_busy;

  // Read ports with bypass of the in-flight writeback.
  always_comb begin
    fwd1     = wr_ok && (rs1_addr == wr_addr);
    fwd2     = wr_ok && (rs2_addr == wr_addr);
    fwd_busy = iss_ok && (issue_rd == wr_addr);
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (run) begin
      if (fwd1) begin
        rs1_data = wr_data;
        rs1_busy = fwd_busy;
      end else begin
        if (rs1_addr != '0) rs1_data = mem[rs1_addr];
        rs1_busy = busy_q[rs1_addr];
      end
      if (fwd2) begin
        rs2_data = wr_data;
        rs2_busy = fwd_busy;
      end else begin
        if (rs2_addr != '0) rs2_data = mem[rs2_addr];
        rs2_busy = busy_q[rs2_addr];
      end
    end
  end
`else
  // Read ports; x0 and the whole INIT phase read as zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (run) begin
      if (rs1_addr != '0) rs1_data = mem[rs1_addr];
      if (rs2_addr != '0) rs2_data = mem[rs2_addr];
      rs1_busy = busy_q[rs1_addr];
      rs2_busy = busy_q[rs2_addr];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb.
// Expected reads are queued as stimulus is applied.
module tb_reg_file_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] m_mem [NREGS];
  logic            m_busy[NREGS];

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .ready(ready)
  );

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic w, input logic [AW-1:0] wa,
                             input logic [XLEN-1:0] wd,
                             input logic is, input logic [AW-1:0] rd);
    if (w && wa != 0) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (is && rd != 0) m_busy[rd] = 1'b1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    e.data = (a == 0) ? '0 : m_mem[a];
    e.busy = (a == 0) ? 1'b0 : m_busy[a];
    sb.push_back(e);
  endtask

  task automatic op(input logic w, input logic [AW-1:0] wa,
                    input logic [XLEN-1:0] wd,
                    input logic is, input logic [AW-1:0] rd);
    wr_en    = w;
    wr_addr  = wa;
    wr_data  = wd;
    issue_en = is;
    issue_rd = rd;
    @(negedge clk);
    wr_en    = 1'b0;
    issue_en = 1'b0;
    model_apply(w, wa, wd, is, rd);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rs1_addr = e.addr;
      rs2_addr = e.addr;
      #1;
      checks++;
      if (rs1_data !== e.data || rs1_busy !== e.busy ||
          rs2_data !== e.data || rs2_busy !== e.busy) begin
        errors++;
        $display("FAIL %s x%0d: got rs1=%h/%b rs2=%h/%b want %h/%b",
                 tag, e.addr, rs1_data, rs1_busy, rs2_data, rs2_busy,
                 e.data, e.busy);
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rs1_addr = 5'd3;
    #1;
    checks++;
    if (ready !== 1'b0 || rs1_busy !== 1'b0 || rs1_data !== '0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b busy=%b data=%h want 0/0/0",
               ready, rs1_busy, rs1_data);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    checks++;
    if (n != NREGS) begin
      errors++;
      $display("FAIL clear_len: ready after %0d cycles want %0d", n, NREGS);
    end
    model_clear();
    for (int i = 0; i < NREGS; i++) push_exp(AW'(i));
    drain("clear");
  endtask

  task automatic test_basic();
    op(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005, 1'b0, 5'd0);
    push_exp(5'd5);
    push_exp(5'd0);
    drain("basic");
    op(1'b1, 5'd31, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0);
    push_exp(5'd31);
    push_exp(5'd5);
    drain("basic_hi");
  endtask

  task automatic test_x0();
    op(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0);
    push_exp(5'd0);
    drain("x0");
  endtask

  task automatic test_scoreboard();
    op(1'b0, 5'd0, '0, 1'b1, 5'd7);
    push_exp(5'd7);
    drain("issue");
    op(1'b1, 5'd7, 64'h42, 1'b0, 5'd0);
    push_exp(5'd7);
    drain("wb_clear");
    op(1'b1, 5'd7, 64'h42, 1'b1, 5'd7);
    push_exp(5'd7);
    drain("set_wins");
    op(1'b1, 5'd7, 64'h55, 1'b1, 5'd8);
    push_exp(5'd7);
    push_exp(5'd8);
    drain("diff_regs");
    op(1'b0, 5'd0, '0, 1'b1, 5'd8);
    op(1'b1, 5'd8, 64'h88, 1'b0, 5'd0);
    push_exp(5'd8);
    drain("no_count");
    op(1'b1, 5'd10, 64'hA, 1'b0, 5'd0);
    push_exp(5'd10);
    drain("wr_idle");
  endtask

  task automatic test_forward();
    logic [XLEN-1:0] ed;
    logic            eb;
    @(negedge clk);
    rs2_addr = 5'd3;
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 64'h99;
    #1;
`ifdef REG_FILE_FORWARD_EN
    ed = 64'h99;
    eb = 1'b0;
`else
    ed = m_mem[3];
    eb = m_busy[3];
`endif
    checks++;
    if (rs2_data !== ed || rs2_busy !== eb) begin
      errors++;
      $display("FAIL fwd_same: got %h/%b want %h/%b",
               rs2_data, rs2_busy, ed, eb);
    end
    @(negedge clk);
    wr_en = 1'b0;
    model_apply(1'b1, 5'd3, 64'h99, 1'b0, 5'd0);
    push_exp(5'd3);
    drain("fwd_next");
    @(negedge clk);
    rs2_addr = 5'd3;
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 64'h77;
    issue_en = 1'b1;
    issue_rd = 5'd3;
    #1;
`ifdef REG_FILE_FORWARD_EN
    ed = 64'h77;
    eb = 1'b1;
`else
    ed = m_mem[3];
    eb = m_busy[3];
`endif
    checks++;
    if (rs2_data !== ed || rs2_busy !== eb) begin
      errors++;
      $display("FAIL fwd_issue: got %h/%b want %h/%b",
               rs2_data, rs2_busy, ed, eb);
    end
    @(negedge clk);
    wr_en    = 1'b0;
    issue_en = 1'b0;
    model_apply(1'b1, 5'd3, 64'h77, 1'b1, 5'd3);
    push_exp(5'd3);
    drain("fwd_issue_next");
  endtask

  task automatic test_reset_mid();
    int n;
    op(1'b1, 5'd9, 64'h11, 1'b1, 5'd4);
    push_exp(5'd9);
    push_exp(5'd4);
    drain("pre_rst");
    @(negedge clk);
    rs1_addr = 5'd4;
    rs2_addr = 5'd9;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rs1_busy !== 1'b0 || rs2_data !== '0 ||
        dut.busy_q !== '0) begin
      errors++;
      $display("FAIL mid_rst: ready=%b busy=%b data=%h bq=%h want 0",
               ready, rs1_busy, rs2_data, dut.busy_q);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    checks++;
    if (n != NREGS) begin
      errors++;
      $display("FAIL mid_clear_len: ready after %0d want %0d", n, NREGS);
    end
    model_clear();
    push_exp(5'd9);
    push_exp(5'd4);
    drain("post_rst");
  endtask

  initial begin
    rst      = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
    model_clear();
    test_reset();
    test_basic();
    test_x0();
    test_scoreboard();
    test_forward();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
